// File: rtl/seg7_capture16.sv
// seg7_capture16
// Rebuilds 16-bit words from a stream of active-low seven-segment glyphs.
// Digits arrive most-significant first, one per seg_valid/seg_ready
// handshake. Each glyph is decoded to a nibble, and four nibbles form a word.
// The word is held in a single-entry output register and offered under a
// word_valid/word_ready handshake. A glyph that is not a legal hex digit
// raises err and throws away the partial word.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   clearn      synchronous active-low reset
//   seg_in      segment pattern, bit0 = a .. bit6 = g, 0 = lit
//   seg_valid   seg_in holds a digit
//   seg_ready   a digit can be accepted this cycle (COLLECT state)
//   word        assembled value; the first digit received is in word[15:12]
//   word_valid  word is held and valid (HOLD state)
//   word_ready  consumer accepts word
//   err         illegal glyph detected
//   digit_cnt   number of digits collected toward the current word
//
// Configuration macro: SEG7_CAP_STICKY_ERR_EN
//   defined   -> err stays high after the first illegal glyph until reset
//   undefined -> err pulses for one cycle after each illegal glyph
module seg7_capture16 (
  input  logic        clk,
  input  logic        clearn,
  input  logic [6:0]  seg_in,
  input  logic        seg_valid,
  output logic        seg_ready,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        err,
  output logic [1:0]  digit_cnt
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t      state;
  logic [11:0] shift;
  logic [3:0]  nibble;
  logic        legal;
  logic        accept;
  logic        bad_accept;

  // Glyph decoder: maps the 16 legal active-low patterns back to nibbles.
  // Every other pattern is illegal.
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg_in)
      7'h40: nibble = 4'h0;
      7'h79: nibble = 4'h1;
      7'h24: nibble = 4'h2;
      7'h30: nibble = 4'h3;
      7'h19: nibble = 4'h4;
      7'h12: nibble = 4'h5;
      7'h02: nibble = 4'h6;
      7'h78: nibble = 4'h7;
      7'h00: nibble = 4'h8;
      7'h18: nibble = 4'h9;
      7'h08: nibble = 4'hA;
      7'h03: nibble = 4'hB;
      7'h46: nibble = 4'hC;
      7'h21: nibble = 4'hD;
      7'h06: nibble = 4'hE;
      7'h0E: nibble = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // seg_ready comes straight from the state register. No digit is taken
  // while a word is held, so a handshake leaves a one-cycle bubble.
  assign seg_ready  = (state == COLLECT);
  assign accept     = seg_valid & seg_ready;
  assign bad_accept = accept & ~legal;

  // Collection and hold control. Reset takes priority over any handshake
  // on the same edge.
  always_ff @(posedge clk) begin
    if (!clearn) begin
      state      <= COLLECT;
      shift      <= 12'h000;
      digit_cnt  <= 2'd0;
      word       <= 16'h0000;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
`ifdef SEG7_CAP_STICKY_ERR_EN
      if (bad_accept)
        err <= 1'b1;
`else
      err <= bad_accept;
`endif
      case (state)
        COLLECT: begin
          if (accept) begin
            if (legal) begin
              shift <= {shift[7:0], nibble};
              if (digit_cnt == 2'd3) begin
                word       <= {shift, nibble};
                word_valid <= 1'b1;
                digit_cnt  <= 2'd0;
                state      <= HOLD;
              end else begin
                digit_cnt <= digit_cnt + 2'd1;
              end
            end else begin
              // An illegal glyph is consumed and discards the partial word.
              shift     <= 12'h000;
              digit_cnt <= 2'd0;
            end
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture16.sv
// tb_seg7_capture16
// Directed self-checking bench for seg7_capture16. Inputs are driven 1 ns
// after each rising edge. Outputs are checked at the same point, so every
// check sees the result of the edge that just occurred.
module tb_seg7_capture16;

`ifdef SEG7_CAP_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clearn;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        err;
  logic [1:0]  digit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] legal_words [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
  logic [6:0]  bad [8] = '{7'h7F, 7'h01, 7'h41, 7'h7E, 7'h0F, 7'h22, 7'h55, 7'h6B};

  seg7_capture16 dut (
    .clk        (clk),
    .clearn     (clearn),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err        (err),
    .digit_cnt  (digit_cnt)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point; counts every evaluation and every failure.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs against one expected set.
  task automatic checkState(input string tag, input logic [15:0] w, input logic wv,
                            input logic sr, input logic [1:0] cnt, input logic e);
    checkOutput($sformatf("%s.word", tag), word, w);
    checkOutput($sformatf("%s.word_valid", tag), {15'd0, word_valid}, {15'd0, wv});
    checkOutput($sformatf("%s.seg_ready", tag), {15'd0, seg_ready}, {15'd0, sr});
    checkOutput($sformatf("%s.digit_cnt", tag), {14'd0, digit_cnt}, {14'd0, cnt});
    checkOutput($sformatf("%s.err", tag), {15'd0, err}, {15'd0, e});
  endtask

  // Drives the inputs for one cycle, then moves to the check point after the edge.
  task automatic applyStimulus(input logic [6:0] seg, input logic sv, input logic wr);
    seg_in     = seg;
    seg_valid  = sv;
    word_ready = wr;
    @(posedge clk);
    #1;
  endtask

  // Holds reset for one edge, checks the reset state, then releases it.
  task automatic applyReset(input string tag);
    clearn = 1'b0;
    applyStimulus(7'h79, 1'b1, 1'b1);
    checkState(tag, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0);
    clearn = 1'b1;
  endtask

  initial begin
    clearn     = 1'b0;
    seg_in     = 7'h00;
    seg_valid  = 1'b0;
    word_ready = 1'b0;
    $display("[TB] start, sticky err mode = %0d", STICKY);

    // Reset state.
    applyStimulus(7'h00, 1'b0, 1'b0);
    checkState("reset", 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0);
    clearn = 1'b1;

    // Word 1234 with the consumer always ready.
    applyStimulus(7'h79, 1'b1, 1'b1);
    checkState("t1.d1", 16'h0000, 1'b0, 1'b1, 2'd1, 1'b0);
    applyStimulus(7'h24, 1'b1, 1'b1);
    checkState("t1.d2", 16'h0000, 1'b0, 1'b1, 2'd2, 1'b0);
    applyStimulus(7'h30, 1'b1, 1'b1);
    checkState("t1.d3", 16'h0000, 1'b0, 1'b1, 2'd3, 1'b0);
    applyStimulus(7'h19, 1'b1, 1'b1);
    checkState("t1.d4", 16'h1234, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b1);
    checkState("t1.ack", 16'h1234, 1'b0, 1'b1, 2'd0, 1'b0);

    // Word ABCD held for 5 cycles while seg_valid pulses are ignored.
    applyStimulus(7'h08, 1'b1, 1'b0);
    applyStimulus(7'h03, 1'b1, 1'b0);
    applyStimulus(7'h46, 1'b1, 1'b0);
    checkState("t2.d3", 16'h1234, 1'b0, 1'b1, 2'd3, 1'b0);
    applyStimulus(7'h21, 1'b1, 1'b0);
    checkState("t2.d4", 16'hABCD, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2 == 0) ? 7'h7F : 7'h79, 1'b1, 1'b0);
      checkState($sformatf("t2.hold%0d", i), 16'hABCD, 1'b1, 1'b0, 2'd0, 1'b0);
    end
    applyStimulus(7'h00, 1'b0, 1'b1);
    checkState("t2.ack", 16'hABCD, 1'b0, 1'b1, 2'd0, 1'b0);

    // Illegal glyph in the middle of a word.
    applyStimulus(7'h40, 1'b1, 1'b1);
    checkState("t3.d0", 16'hABCD, 1'b0, 1'b1, 2'd1, 1'b0);
    applyStimulus(7'h7F, 1'b1, 1'b1);
    checkState("t3.bad", 16'hABCD, 1'b0, 1'b1, 2'd0, 1'b1);
    applyStimulus(7'h18, 1'b1, 1'b1);
    checkState("t3.d9", 16'hABCD, 1'b0, 1'b1, 2'd1, STICKY);
    applyStimulus(7'h06, 1'b1, 1'b1);
    applyStimulus(7'h0E, 1'b1, 1'b1);
    checkState("t3.dF", 16'hABCD, 1'b0, 1'b1, 2'd3, STICKY);
    applyStimulus(7'h00, 1'b1, 1'b1);
    checkState("t3.d8", 16'h9EF8, 1'b1, 1'b0, 2'd0, STICKY);
    applyStimulus(7'h02, 1'b1, 1'b1);
    checkState("t3.ack", 16'h9EF8, 1'b0, 1'b1, 2'd0, STICKY);
    applyStimulus(7'h02, 1'b1, 1'b1);
    checkState("t3.d6", 16'h9EF8, 1'b0, 1'b1, 2'd1, STICKY);

    // All 16 legal glyphs, four per word, then 8 illegal glyphs back to back.
    applyReset("t4.reset");
    for (int w = 0; w < 4; w++) begin
      for (int d = 0; d < 4; d++)
        applyStimulus(glyph[w*4+d], 1'b1, 1'b1);
      checkState($sformatf("t4.word%0d", w), legal_words[w], 1'b1, 1'b0, 2'd0, 1'b0);
      applyStimulus(7'h00, 1'b0, 1'b1);
      checkOutput($sformatf("t4.ack%0d", w), {15'd0, word_valid}, 16'd0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(bad[i], 1'b1, 1'b1);
      checkState($sformatf("t4.bad%0d", i), 16'hCDEF, 1'b0, 1'b1, 2'd0, 1'b1);
    end
    applyStimulus(7'h00, 1'b0, 1'b1);
    checkState("t4.idle", 16'hCDEF, 1'b0, 1'b1, 2'd0, STICKY);

    // Reset after two accepted digits, then a fresh word.
    applyReset("t5.pre");
    applyStimulus(7'h79, 1'b1, 1'b1);
    applyStimulus(7'h24, 1'b1, 1'b1);
    checkState("t5.two", 16'h0000, 1'b0, 1'b1, 2'd2, 1'b0);
    applyReset("t5.midword");
    applyStimulus(7'h12, 1'b1, 1'b0);
    applyStimulus(7'h02, 1'b1, 1'b0);
    applyStimulus(7'h78, 1'b1, 1'b0);
    applyStimulus(7'h00, 1'b1, 1'b0);
    checkState("t5.word", 16'h5678, 1'b1, 1'b0, 2'd0, 1'b0);

    // Reset while a word is held, then a fresh word.
    applyReset("t5.inhold");
    applyStimulus(7'h46, 1'b1, 1'b1);
    applyStimulus(7'h21, 1'b1, 1'b1);
    applyStimulus(7'h06, 1'b1, 1'b1);
    applyStimulus(7'h0E, 1'b1, 1'b1);
    checkState("t5.word2", 16'hCDEF, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b1);

    // A single illegal glyph followed by two complete words.
    applyStimulus(7'h7F, 1'b1, 1'b1);
    checkState("t6.bad", 16'hCDEF, 1'b0, 1'b1, 2'd0, 1'b1);
    applyStimulus(7'h21, 1'b1, 1'b1);
    applyStimulus(7'h40, 1'b1, 1'b1);
    applyStimulus(7'h08, 1'b1, 1'b1);
    applyStimulus(7'h12, 1'b1, 1'b1);
    checkState("t6.word1", 16'hD0A5, 1'b1, 1'b0, 2'd0, STICKY);
    applyStimulus(7'h00, 1'b0, 1'b1);
    applyStimulus(7'h00, 1'b1, 1'b1);
    applyStimulus(7'h18, 1'b1, 1'b1);
    applyStimulus(7'h79, 1'b1, 1'b1);
    applyStimulus(7'h30, 1'b1, 1'b1);
    checkState("t6.word2", 16'h8913, 1'b1, 1'b0, 2'd0, STICKY);
    applyReset("t6.clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
